// File: rtl/enemy_pkg.sv
// Shared definitions for the patrolling enemy: FSM encoding, packed state-word
// layout and wall-collision bit indices.
package enemy_pkg;

   typedef enum logic [2:0] {
      WALK = 3'd0,
      TURN = 3'd1,
      FALL = 3'd2,
      DEAD = 3'd3
   } enemyFsm_t;

   // Low seven bits of the state word: {fsm[2:0], 2'b0, dir, alive}
   localparam int ALIVE_BIT = 0;
   localparam int DIR_BIT   = 1;
   localparam int FSM_LSB   = 4;
   localparam int SPD_LSB   = 7;

   localparam int WALL_LEFT  = 0;
   localparam int WALL_RIGHT = 1;

   function automatic int stateWidth(input int posW, input int spdW);
      return 2 * posW + spdW + 7;
   endfunction

   function automatic int yLsb(input int spdW);
      return SPD_LSB + spdW;
   endfunction

   function automatic int xLsb(input int posW, input int spdW);
      return SPD_LSB + spdW + posW;
   endfunction

   // Shared pause/respawn counter must hold the larger of the two loads
   function automatic int counterWidth(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/tile_snap.sv
// Combinational tile alignment: wall-turn snap for x (projected one step
// ahead) and landing snap for y (last pixel of the tile row above).
module tile_snap #(
   parameter int POS_W = 10,
   parameter int SPD_W = 5,
   parameter int TILE  = 32
) (
   input  logic [POS_W-1:0] xPos,
   input  logic [SPD_W-1:0] xDelta,
   input  logic             dir,
   input  logic [POS_W-1:0] yPos,
   output logic [POS_W-1:0] xSnap,
   output logic [POS_W-1:0] ySnap
);

   localparam logic [POS_W-1:0] TILE_MASK = ~POS_W'(TILE - 1);
   localparam logic [POS_W-1:0] TILE_SIZE = POS_W'(TILE);
   localparam logic [POS_W-1:0] ONE       = POS_W'(1);

   logic [POS_W-1:0] xAhead;
   logic [POS_W-1:0] xAheadTile;

   always_comb begin
      xAhead     = dir ? (xPos + POS_W'(xDelta)) : (xPos - POS_W'(xDelta));
      xAheadTile = xAhead & TILE_MASK;
      // Right wall: stop on the last pixel before the tile; left: first pixel after it
      xSnap      = dir ? (xAheadTile - ONE) : (xAheadTile + TILE_SIZE);
   end

   assign ySnap = (yPos & TILE_MASK) - ONE;

endmodule

// File: rtl/patrol_enemy.sv
// Patrolling enemy: walks, turns at walls with a pause, falls under gravity,
// dies on kill or fall-off and respawns from a snapshot after a countdown.
module patrol_enemy
   import enemy_pkg::*;
#(
   parameter int POS_W          = 10,
   parameter int SPD_W          = 5,
   parameter int TILE           = 32,
   parameter int GRAVITY        = 1,
   parameter int MAX_FALL       = 8,
   parameter int TURN_PAUSE     = 4,
   parameter int RESPAWN_CYCLES = 60,
   parameter int Y_LIMIT        = 480,
   parameter int RST_X          = 200,
   parameter int RST_Y          = 150,
   parameter int RST_SPD        = 3,
   parameter int RST_DIR        = 1,
   localparam int STATE_W       = stateWidth(POS_W, SPD_W)
) (
   input  logic               sim_clk,
   input  logic               reset,
   input  logic               spawn,
   input  logic [STATE_W-1:0] init_state,
   input  logic [1:0]         wall_col,
   input  logic               floor_col,
   input  logic               kill_col,
   output logic [STATE_W-1:0] enemy_state,
   output logic               alive
);

   localparam int X_LSB = xLsb(POS_W, SPD_W);
   localparam int Y_LSB = yLsb(SPD_W);
   localparam int CNT_W = counterWidth(TURN_PAUSE, RESPAWN_CYCLES);

   logic [POS_W-1:0] xReg, xNext, yReg, yNext;
   logic [SPD_W-1:0] spdReg, spdNext, vspdReg, vspdNext;
   logic             dirReg, dirNext, aliveReg, aliveNext;
   logic [CNT_W-1:0] cntReg, cntNext;
   enemyFsm_t        fsmReg, fsmNext;

   logic [POS_W-1:0] snapXReg, snapXNext, snapYReg, snapYNext;
   logic [SPD_W-1:0] snapSpdReg, snapSpdNext;
   logic             snapDirReg, snapDirNext;

   logic [POS_W-1:0] xSnap, ySnap;
   logic [SPD_W:0]   vspdSum;
   logic [SPD_W-1:0] vspdFall;
   logic             wallAhead;
   logic             fallOff;
   logic             unusedInit;

   tile_snap #(
      .POS_W (POS_W),
      .SPD_W (SPD_W),
      .TILE  (TILE)
   ) snapUnit (
      .xPos   (xReg),
      .xDelta (spdReg),
      .dir    (dirReg),
      .yPos   (yReg),
      .xSnap  (xSnap),
      .ySnap  (ySnap)
   );

   assign wallAhead  = dirReg ? wall_col[WALL_RIGHT] : wall_col[WALL_LEFT];
   assign fallOff    = (fsmReg != DEAD) && (32'(yReg) >= Y_LIMIT);
   assign unusedInit = ^{init_state[SPD_LSB-1:DIR_BIT+1], init_state[ALIVE_BIT]};

   // Gravity with saturation; computed one bit wider so the clamp sees overflow
   always_comb begin
      vspdSum  = {1'b0, vspdReg} + (SPD_W+1)'(GRAVITY);
      vspdFall = (vspdSum > (SPD_W+1)'(MAX_FALL)) ? SPD_W'(MAX_FALL) : vspdSum[SPD_W-1:0];
   end

   always_ff @(posedge sim_clk or posedge reset) begin
      if (reset) begin
         xReg       <= POS_W'(RST_X);
         yReg       <= POS_W'(RST_Y);
         spdReg     <= SPD_W'(RST_SPD);
         dirReg     <= 1'(RST_DIR);
         aliveReg   <= 1'b1;
         vspdReg    <= '0;
         cntReg     <= '0;
         fsmReg     <= WALK;
         snapXReg   <= POS_W'(RST_X);
         snapYReg   <= POS_W'(RST_Y);
         snapSpdReg <= SPD_W'(RST_SPD);
         snapDirReg <= 1'(RST_DIR);
      end else begin
         xReg       <= xNext;
         yReg       <= yNext;
         spdReg     <= spdNext;
         dirReg     <= dirNext;
         aliveReg   <= aliveNext;
         vspdReg    <= vspdNext;
         cntReg     <= cntNext;
         fsmReg     <= fsmNext;
         snapXReg   <= snapXNext;
         snapYReg   <= snapYNext;
         snapSpdReg <= snapSpdNext;
         snapDirReg <= snapDirNext;
      end
   end

   always_comb begin
      xNext       = xReg;
      yNext       = yReg;
      spdNext     = spdReg;
      dirNext     = dirReg;
      aliveNext   = aliveReg;
      vspdNext    = vspdReg;
      cntNext     = cntReg;
      fsmNext     = fsmReg;
      snapXNext   = snapXReg;
      snapYNext   = snapYReg;
      snapSpdNext = snapSpdReg;
      snapDirNext = snapDirReg;

      if (spawn) begin
         xNext       = init_state[X_LSB +: POS_W];
         yNext       = init_state[Y_LSB +: POS_W];
         spdNext     = init_state[SPD_LSB +: SPD_W];
         dirNext     = init_state[DIR_BIT];
         snapXNext   = init_state[X_LSB +: POS_W];
         snapYNext   = init_state[Y_LSB +: POS_W];
         snapSpdNext = init_state[SPD_LSB +: SPD_W];
         snapDirNext = init_state[DIR_BIT];
         aliveNext   = 1'b1;
         vspdNext    = '0;
         cntNext     = '0;
         fsmNext     = WALK;
      end else if ((fsmReg != DEAD) && (kill_col || fallOff)) begin
         xNext     = '0;
         yNext     = '0;
         spdNext   = '0;
         aliveNext = 1'b0;
         cntNext   = CNT_W'(RESPAWN_CYCLES);
         fsmNext   = DEAD;
      end else begin
         unique case (fsmReg)
            WALK: begin
               if (!floor_col) begin
                  vspdNext = '0;
                  fsmNext  = FALL;
               end else if (wallAhead) begin
                  xNext   = xSnap;
                  dirNext = ~dirReg;
                  if (TURN_PAUSE > 0) begin
                     cntNext = CNT_W'(TURN_PAUSE);
                     fsmNext = TURN;
                  end
               end else begin
                  xNext = dirReg ? (xReg + POS_W'(spdReg)) : (xReg - POS_W'(spdReg));
               end
            end
            TURN: begin
               if (!floor_col) begin
                  vspdNext = '0;
                  cntNext  = '0;
                  fsmNext  = FALL;
               end else if (cntReg <= CNT_W'(1)) begin
                  cntNext = '0;
                  fsmNext = WALK;
               end else begin
                  cntNext = cntReg - CNT_W'(1);
               end
            end
            FALL: begin
               if (!floor_col) begin
                  vspdNext = vspdFall;
                  yNext    = yReg + POS_W'(vspdFall);
               end else begin
                  yNext    = ySnap;
                  vspdNext = '0;
                  fsmNext  = WALK;
               end
            end
            DEAD: begin
               // A zero counter means respawn only through spawn
               if (cntReg != '0) begin
                  cntNext = cntReg - CNT_W'(1);
                  if (cntReg == CNT_W'(1)) begin
                     xNext     = snapXReg;
                     yNext     = snapYReg;
                     spdNext   = snapSpdReg;
                     dirNext   = snapDirReg;
                     aliveNext = 1'b1;
                     vspdNext  = '0;
                     fsmNext   = WALK;
                  end
               end
            end
            default: begin
               fsmNext = WALK;
            end
         endcase
      end
   end

   always_comb begin
      enemy_state                      = '0;
      enemy_state[X_LSB +: POS_W]      = xReg;
      enemy_state[Y_LSB +: POS_W]      = yReg;
      enemy_state[SPD_LSB +: SPD_W]    = spdReg;
      enemy_state[FSM_LSB +: 3]        = fsmReg;
      enemy_state[DIR_BIT]             = dirReg;
      enemy_state[ALIVE_BIT]           = aliveReg;
   end

   assign alive = aliveReg;

endmodule

// File: tb/tb_patrol_enemy.sv
module tb_patrol_enemy;

   localparam int TILE       = 32;
   localparam int GRAV       = 1;
   localparam int MAXF       = 4;
   localparam int PAUSE      = 4;
   localparam int RESPAWN    = 60;
   localparam int YLIM       = 480;
   localparam int WRAP       = 1024;
   localparam int M_WALK     = 0;
   localparam int M_TURN     = 1;
   localparam int M_FALL     = 2;
   localparam int M_DEAD     = 3;
   localparam logic [31:0] RESET_WORD = {10'd200, 10'd150, 5'd3, 3'd0, 2'b00, 1'b1, 1'b1};

   logic        sim_clk;
   logic        reset;
   logic        spawn;
   logic [31:0] init_state;
   logic [1:0]  wall_col;
   logic        floor_col;
   logic        kill_col;
   logic [31:0] enemy_state;
   logic        alive;

   patrol_enemy #(
      .MAX_FALL (MAXF)
   ) dut (
      .sim_clk     (sim_clk),
      .reset       (reset),
      .spawn       (spawn),
      .init_state  (init_state),
      .wall_col    (wall_col),
      .floor_col   (floor_col),
      .kill_col    (kill_col),
      .enemy_state (enemy_state),
      .alive       (alive)
   );

   initial begin
      sim_clk = 1'b0;
      forever #5 sim_clk = ~sim_clk;
   end

   int checks = 0;
   int passes = 0;
   int txn    = 0;
   logic [31:0] expQ[$];

   int mX, mY, mSpd, mDir, mAlive, mMode, mV, mCnt;
   int sX, sY, sSpd, sDir;

   function automatic bit check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) begin
         passes++;
         return 1'b1;
      end
      $display("FAIL %s: got %h, expected %h", name, got, exp);
      return 1'b0;
   endfunction

   function automatic int wrapPos(input int v);
      return ((v % WRAP) + WRAP) % WRAP;
   endfunction

   function automatic int tileBase(input int v);
      return (v / TILE) * TILE;
   endfunction

   function automatic void modelReset();
      mX = 200; mY = 150; mSpd = 3; mDir = 1; mAlive = 1;
      mMode = M_WALK; mV = 0; mCnt = 0;
      sX = 200; sY = 150; sSpd = 3; sDir = 1;
   endfunction

   function automatic logic [31:0] modelWord();
      return {10'(mX), 10'(mY), 5'(mSpd), 3'(mMode), 2'b00, 1'(mDir), 1'(mAlive)};
   endfunction

   function automatic void modelStep(input logic sp, input logic [31:0] init,
                                     input logic [1:0] wc, input logic fc, input logic kc);
      int nx;
      if (sp) begin
         mX = int'(init[31:22]); mY = int'(init[21:12]);
         mSpd = int'(init[11:7]); mDir = int'(init[1]);
         sX = mX; sY = mY; sSpd = mSpd; sDir = mDir;
         mMode = M_WALK; mAlive = 1; mV = 0; mCnt = 0;
      end else if (mMode != M_DEAD && (kc || mY >= YLIM)) begin
         mX = 0; mY = 0; mSpd = 0; mAlive = 0; mMode = M_DEAD; mCnt = RESPAWN;
      end else begin
         case (mMode)
            M_WALK: begin
               if (!fc) begin
                  mMode = M_FALL; mV = 0;
               end else if (wc[mDir] == 1'b1) begin
                  if (mDir == 1) begin
                     nx = wrapPos(mX + mSpd);
                     mX = wrapPos(tileBase(nx) - 1);
                  end else begin
                     nx = wrapPos(mX - mSpd);
                     mX = wrapPos(tileBase(nx) + TILE);
                  end
                  mDir = 1 - mDir;
                  if (PAUSE > 0) begin
                     mMode = M_TURN; mCnt = PAUSE;
                  end
               end else begin
                  mX = (mDir == 1) ? wrapPos(mX + mSpd) : wrapPos(mX - mSpd);
               end
            end
            M_TURN: begin
               if (!fc) begin
                  mMode = M_FALL; mV = 0;
               end else begin
                  mCnt = mCnt - 1;
                  if (mCnt <= 0) mMode = M_WALK;
               end
            end
            M_FALL: begin
               if (!fc) begin
                  mV = (mV + GRAV > MAXF) ? MAXF : mV + GRAV;
                  mY = wrapPos(mY + mV);
               end else begin
                  mY = wrapPos(tileBase(mY) - 1);
                  mV = 0; mMode = M_WALK;
               end
            end
            default: begin
               if (mCnt > 0) begin
                  mCnt = mCnt - 1;
                  if (mCnt == 0) begin
                     mX = sX; mY = sY; mSpd = sSpd; mDir = sDir;
                     mAlive = 1; mMode = M_WALK; mV = 0;
                  end
               end
            end
         endcase
      end
   endfunction

   function automatic logic [31:0] mkInit(input int x, input int y, input int spd, input int dir, input logic [6:0] junk);
      return {10'(x), 10'(y), 5'(spd), junk[6:2], 1'(dir), junk[0]};
   endfunction

   task automatic step(input logic sp, input logic [31:0] init, input logic [1:0] wc,
                       input logic fc, input logic kc);
      spawn = sp; init_state = init; wall_col = wc; floor_col = fc; kill_col = kc;
      @(posedge sim_clk);
      modelStep(sp, init, wc, fc, kc);
      expQ.push_back(modelWord());
      #1;
   endtask

   initial begin
      logic [31:0] e;
      forever begin
         @(negedge sim_clk);
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            txn++;
            if (check("state", {31'b0, alive, enemy_state}, {31'b0, e[0], e}))
               $display("txn %0d state=%h ok", txn, enemy_state);
         end
      end
   end

   initial begin
      logic [6:0] junk;
      int floorRun;
      logic floorVal;
      reset = 1'b0; spawn = 1'b0; init_state = '0; wall_col = 2'b00;
      floor_col = 1'b1; kill_col = 1'b0;
      #1 reset = 1'b1;
      #1 void'(check("reset_async", {31'b0, alive, enemy_state}, {31'b0, 1'b1, RESET_WORD}));
      modelReset();
      #20 reset = 1'b0;

      step(0, '0, 2'b00, 1, 0);
      step(0, '0, 2'b00, 1, 0);
      void'(check("walk_x", 64'(enemy_state[31:22]), 64'd206));
      checks++;
      if (enemy_state[21:12] === 10'd150) passes++;
      else $display("FAIL walk_y: got %0d, expected 150", enemy_state[21:12]);
      void'(check("walk_fsm", 64'(enemy_state[6:4]), 64'd0));

      for (int i = 0; i < 6; i++) step(0, '0, 2'b00, 0, 0);
      void'(check("fall_y", 64'(enemy_state[21:12]), 64'd164));
      step(0, '0, 2'b00, 1, 0);
      void'(check("land_y", 64'(enemy_state[21:12]), 64'd159));
      checks++;
      if (enemy_state[6:4] === 3'd0) passes++;
      else $display("FAIL land_fsm: got %0d, expected 0", enemy_state[6:4]);

      step(0, '0, 2'b00, 1, 1);
      checks++;
      if (enemy_state === {25'b0, 3'd3, 2'b00, 1'b1, 1'b0}) passes++;
      else $display("FAIL kill_word: got %h", enemy_state);
      for (int i = 0; i < 60; i++) step(0, '0, 2'b00, 1, 0);
      void'(check("respawn_x", 64'(enemy_state[31:22]), 64'd200));
      void'(check("respawn_alive", 64'(alive), 64'd1));

      step(1, mkInit(100, 150, 3, 0, 7'h55), 2'b00, 1, 1);
      void'(check("spawn_x", 64'(enemy_state[31:22]), 64'd100));
      checks++;
      if (alive === 1'b1) passes++;
      else $display("FAIL spawn_alive: got %b, expected 1", alive);
      step(0, '0, 2'b01, 1, 0);
      void'(check("lwall_x", 64'(enemy_state[31:22]), 64'd128));
      checks++;
      if (enemy_state[1] === 1'b1) passes++;
      else $display("FAIL lwall_dir: got %b, expected 1", enemy_state[1]);

      step(1, mkInit(220, 150, 3, 1, 7'h00), 2'b00, 1, 0);
      step(0, '0, 2'b10, 1, 0);
      void'(check("rwall_x", 64'(enemy_state[31:22]), 64'd191));
      void'(check("rwall_fsm", 64'(enemy_state[6:4]), 64'd1));
      for (int i = 0; i < 5; i++) step(0, '0, 2'b10, 1, 0);
      void'(check("after_turn_x", 64'(enemy_state[31:22]), 64'd188));

      step(0, '0, 2'b00, 1, 1);
      for (int i = 0; i < 10; i++) step(0, '0, 2'b00, 1, 0);
      @(negedge sim_clk);
      #1 reset = 1'b1;
      #1 void'(check("reset_mid_dead", {31'b0, alive, enemy_state}, {31'b0, 1'b1, RESET_WORD}));
      modelReset();
      #1 reset = 1'b0;

      for (int i = 0; i < 100; i++) step(0, '0, 2'b00, 0, 0);
      for (int i = 0; i < 70; i++) step(0, '0, 2'b00, 1, 0);

      floorRun = 0;
      floorVal = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if (floorRun == 0) begin
            floorVal = ($urandom_range(0, 99) < 85);
            floorRun = floorVal ? $urandom_range(3, 30) : $urandom_range(1, 12);
         end
         floorRun--;
         junk = 7'($urandom);
         step(($urandom_range(0, 63) == 0),
              mkInit($urandom_range(0, 1023), $urandom_range(0, 520),
                     $urandom_range(0, 31), $urandom_range(0, 1), junk),
              (($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00) |
              (($urandom_range(0, 5) == 0) ? 2'b01 : 2'b00),
              floorVal,
              ($urandom_range(0, 49) == 0));
      end

      spawn = 1'b0; kill_col = 1'b0;
      repeat (2) @(negedge sim_clk);
      #1 void'(check("drain", 64'(expQ.size()), 64'd0));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/patrol_enemy.md
# patrol_enemy

Parametrised next-generation patrolling enemy for the Slime Knight game logic. It walks horizontally, reverses on wall collision with a configurable pause, and falls under gravity when it loses floor contact. It dies on a kill collision or by falling off-screen, then respawns after a countdown. It sits alongside the player and level-collision logic on the simulation clock and publishes one packed state word for the renderer and collision units.

## Interface
Parameters:
- POS_W, 10, x/y position width
- SPD_W, 5, horizontal speed width (vertical speed uses the same width)
- TILE, 32, tile size in pixels; power of two
- GRAVITY, 1, vertical speed increment per cycle while falling
- MAX_FALL, 8, vertical speed clamp
- TURN_PAUSE, 4, idle cycles after a wall turn; 0 means no pause
- RESPAWN_CYCLES, 60, cycles spent in DEAD before respawn; 0 means stay dead until `spawn`
- Y_LIMIT, 480, y at or beyond which the enemy dies
- RST_X / RST_Y / RST_SPD / RST_DIR, 200 / 150 / 3 / 1, reset spawn point, speed and direction

Ports:
- sim_clk  in  1  clock
- reset  in  1  asynchronous, active-high; forces the reset state immediately
- spawn  in  1  synchronous load of `init_state` as both live state and respawn snapshot
- init_state  in  STATE_W  packed spawn state, same layout as `enemy_state`
- wall_col  in  2  bit0 = left wall hit, bit1 = right wall hit
- floor_col  in  1  1 = standing on floor
- kill_col  in  1  player kill hit
- enemy_state  out  STATE_W  packed {x[POS_W], y[POS_W], xspd[SPD_W], fsm[2:0], 2'b0, dir, alive}, where STATE_W = 2*POS_W+SPD_W+7 (32 at defaults)
- alive  out  1  copy of enemy_state[0]

## Operation
- FSM states: WALK=0, TURN=1, FALL=2, DEAD=3.
- Reset values: x=RST_X, y=RST_Y, xspd=RST_SPD, dir=RST_DIR, fsm=WALK, alive=1, vspd=0, counters=0. The snapshot is loaded with the same values.
- Per-cycle priority: spawn > kill > fall-off > FSM.
- spawn: load x, y, xspd, dir from `init_state` into both the live registers and the snapshot. Set fsm=WALK, alive=1, vspd=0. Fields [6:0] of `init_state` other than dir are ignored.
- kill_col in any state except DEAD: x=y=xspd=0, alive=0, fsm=DEAD, counter=RESPAWN_CYCLES. kill_col while DEAD is ignored.
- WALK:
  - floor_col=0: go to FALL with vspd=0; x does not move this cycle.
  - Otherwise, if (dir ? wall_col[1] : wall_col[0]) is set, snap and turn:
    - left: nx=x-xspd; x=(nx & ~(TILE-1))+TILE.
    - right: nx=x+xspd; x=(nx & ~(TILE-1))-1.
    - Flip dir. Go to TURN with counter=TURN_PAUSE, or stay in WALK if TURN_PAUSE=0.
  - Otherwise x += xspd (right) or x -= xspd (left), modulo 2^POS_W.
  - A wall bit on the side the enemy is not moving toward is ignored.
- TURN: x and y hold and the counter decrements. When it reaches 1, go to WALK. floor_col=0 goes to FALL immediately.
- FALL:
  - floor_col=0: vspd=min(vspd+GRAVITY, MAX_FALL), y += new vspd; x holds.
  - floor_col=1: y=(y & ~(TILE-1))-1, vspd=0, fsm=WALK.
- Fall-off: y ≥ Y_LIMIT after any update is treated as a kill on the following cycle.
- DEAD: the counter decrements. On the cycle it reaches 0, restore the snapshot and set fsm=WALK, alive=1. With RESPAWN_CYCLES=0, stay in DEAD until spawn.

## Timing
- All state is registered. enemy_state reflects the inputs sampled on the previous edge (latency 1).
- Collision inputs are sampled every cycle; there is no handshake.
- reset assertion clears outputs asynchronously. Release is synchronous to the next sim_clk edge.
- spawn in the same cycle as kill_col: spawn wins and the enemy is alive.
- reset asserted mid-fall or mid-respawn abandons the countdown. The snapshot returns to RST_* values.
- Arithmetic is unsigned at POS_W bits. Underflow and overflow wrap; no saturation except vspd.

## Structure
- Shared package `enemy_pkg`:
  - FSM encoding.
  - Field offsets / STATE_W function.
  - Wall-bit indices.
- One sub-module `tile_snap` (combinational):
  - Inputs: position, delta, direction.
  - Outputs: the snapped coordinate, for both the horizontal and landing cases.
- The FSM, counters and registers live in `patrol_enemy`.

## Test plan
- Reset, then 2 WALK cycles with floor_col=1, no walls → x=200,203,206; y=150; fsm=0.
- Right wall at x=220, xspd=3 → x=191, dir=0, fsm=TURN for 4 cycles with x held, then x=188.
- floor_col=0 from y=150, GRAVITY=1, MAX_FALL=4 → y=151,153,156,160,164. Then floor_col=1 → y=159, fsm=WALK.
- kill_col pulse → state word {0,0,0,DEAD,dir,0}. After 60 cycles → x=200, y=150, alive=1, fsm=WALK.
- spawn with x=100, dir=0, and kill_col in the same cycle → x=100, alive=1. Left wall next cycle (nx=97) → x=128, dir=1.
- reset asserted mid-DEAD countdown → outputs return to RST_* values immediately without a clock edge.
